// File: rtl/imem_loader.sv
// Byte-streamed instruction memory loader.
// LOAD: assembles little-endian 32-bit words from an 8-bit stream into mem.
// RUN:  serves single-cycle-latency instruction fetches, flagging misaligned
//       or out-of-range addresses with a NOP response.
module imem_loader #(
  parameter int          DEPTH    = 32,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        reload,
  output logic        load_done,
  output logic [5:0]  load_count,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_err
);

  localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_r;
  logic [0:0]    state_nxt_s;
  logic [31:0]   mem_r [DEPTH];
  logic [PW-1:0] word_ptr_r;
  logic [1:0]    byte_cnt_r;
  logic [23:0]   asm_r;
  logic [5:0]    load_count_r;
  logic          load_ready_r;
  logic          load_done_r;
  logic          fetch_valid_r;
  logic [31:0]   fetch_instr_r;
  logic          fetch_err_r;

  logic          accept_s;
  logic          write_s;
  logic [31:0]   word_s;
  logic          fetch_hit_s;
  logic          fetch_bad_s;
  logic [PW-1:0] fetch_idx_s;
  logic [31:0]   fetch_data_s;

  assign load_ready  = load_ready_r;
  assign load_done   = load_done_r;
  assign load_count  = load_count_r;
  assign fetch_valid = fetch_valid_r;
  assign fetch_instr = fetch_instr_r;
  assign fetch_err   = fetch_err_r;

  // Word assembly: the incoming byte lands at the byte-counter lane, lanes above it are zero.
  always_comb begin
    accept_s = load_valid && load_ready_r;
    case (byte_cnt_r)
      2'd0:    word_s = {24'h000000, load_data};
      2'd1:    word_s = {16'h0000, load_data, asm_r[7:0]};
      2'd2:    word_s = {8'h00, load_data, asm_r[15:0]};
      2'd3:    word_s = {load_data, asm_r[23:0]};
      default: word_s = NOP_WORD;
    endcase
    write_s = accept_s && ((byte_cnt_r == 2'd3) || load_last);
  end

  // Next-state decision: leave LOAD after the final write, leave RUN on reload.
  always_comb begin
    case (state_r)
      ST_LOAD: begin
        if (write_s && (load_last || (word_ptr_r == LAST_PTR))) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (reload) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Fetch decode: misaligned or beyond the stored program returns NOP with an error flag.
  always_comb begin
    fetch_hit_s = (state_r == ST_RUN) && fetch_req;
    fetch_bad_s = (fetch_addr[1:0] != 2'b00) || ({24'h000000, fetch_addr} >= ADDR_LIMIT);
    fetch_idx_s = PW'(fetch_addr[7:2]);
    if (fetch_bad_s) begin
      fetch_data_s = NOP_WORD;
    end else begin
      fetch_data_s = mem_r[fetch_idx_s];
    end
  end

  // Load control: state, status outputs, byte/word counters and partial-word staging.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_LOAD;
      load_ready_r <= 1'b1;
      load_done_r  <= 1'b0;
      word_ptr_r   <= '0;
      byte_cnt_r   <= 2'd0;
      asm_r        <= 24'h000000;
      load_count_r <= 6'd0;
    end else begin
      state_r      <= state_nxt_s;
      load_ready_r <= (state_nxt_s == ST_LOAD);
      load_done_r  <= (state_nxt_s == ST_RUN);
      if ((state_r == ST_RUN) && reload) begin
        word_ptr_r   <= '0;
        byte_cnt_r   <= 2'd0;
        load_count_r <= 6'd0;
      end else if (write_s) begin
        word_ptr_r   <= word_ptr_r + PW'(1);
        byte_cnt_r   <= 2'd0;
        load_count_r <= load_count_r + 6'd1;
      end else if (accept_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        case (byte_cnt_r)
          2'd0:    asm_r[7:0]   <= load_data;
          2'd1:    asm_r[15:8]  <= load_data;
          2'd2:    asm_r[23:16] <= load_data;
          default: asm_r        <= asm_r;
        endcase
      end
    end
  end

  // Instruction storage: reset fills with NOP, loads overwrite one word at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= NOP_WORD;
      end
    end else if (write_s) begin
      mem_r[word_ptr_r] <= word_s;
    end
  end

  // Fetch response register: one-cycle latency, data and error held between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid_r <= 1'b0;
      fetch_instr_r <= 32'h00000000;
      fetch_err_r   <= 1'b0;
    end else if (fetch_hit_s) begin
      fetch_valid_r <= 1'b1;
      fetch_instr_r <= fetch_data_s;
      fetch_err_r   <= fetch_bad_s;
    end else begin
      fetch_valid_r <= 1'b0;
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the number of 32-bit instruction words stored.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h00000013, meaning the fill and error value (addi x0,x0,0).
REQ-003 The block SHALL have port clk, input, 1 bit, the clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port load_valid, input, 1 bit, meaning a load byte is offered.
REQ-006 The block SHALL have port load_data, input, 8 bits, the load byte.
REQ-007 The block SHALL have port load_last, input, 1 bit, marking the offered byte as the final program byte.
REQ-008 The block SHALL have port load_ready, output, 1 bit, meaning the block accepts a byte this cycle.
REQ-009 The block SHALL have port reload, input, 1 bit, a single-cycle request to re-enter loading.
REQ-010 The block SHALL have port load_done, output, 1 bit, meaning the program is loaded and fetches are served.
REQ-011 The block SHALL have port load_count, output, 6 bits, the number of words written in the current load.
REQ-012 The block SHALL have port fetch_req, input, 1 bit, the fetch request from the core.
REQ-013 The block SHALL have port fetch_addr, input, 8 bits, the byte address (PC).
REQ-014 The block SHALL have port fetch_valid, output, 1 bit, meaning fetch_instr/fetch_err are valid.
REQ-015 The block SHALL have port fetch_instr, output, 32 bits, the returned instruction.
REQ-016 The block SHALL have port fetch_err, output, 1 bit, flagging a misaligned or out-of-range fetch.

Function
REQ-017 The block SHALL implement two states, LOAD and RUN, and SHALL enter LOAD on reset.
REQ-018 In LOAD, load_ready SHALL be 1, and a byte SHALL be accepted in any cycle where load_valid and load_ready are both 1.
REQ-019 Accepted bytes SHALL be assembled little-endian: byte 0 goes to [7:0] and byte 3 to [31:24], tracked by a 2-bit byte counter.
REQ-020 On acceptance of the 4th byte, the assembled word SHALL be written to mem[word_ptr]; word_ptr and load_count SHALL then increment, and the byte counter SHALL wrap to 0.
REQ-021 On acceptance of a byte with load_last=1 and an incomplete word, the byte SHALL be placed and the unfilled upper bytes SHALL be zero before the word is written.
REQ-022 The block SHALL transition LOAD->RUN in the cycle after the write that (a) contains the load_last byte, or (b) is word DEPTH-1.
REQ-023 Bytes offered after DEPTH words have been written SHALL NOT be accepted, because load_ready is already 0.
REQ-024 In RUN: load_ready=0 and load_done=1; in LOAD: load_done=0.
REQ-025 In RUN, a fetch_req=1 SHALL produce, exactly one cycle later: fetch_valid=1 and fetch_instr=mem[fetch_addr[6:2]]; back-to-back requests SHALL be served every cycle.
REQ-026 If fetch_addr[1:0]!=0 or fetch_addr>=4*DEPTH, the response SHALL have fetch_err=1 and fetch_instr=NOP_WORD.
REQ-027 fetch_req in LOAD SHALL be dropped: no response is generated.
REQ-028 fetch_valid SHALL be 0 in every cycle not required by REQ-025; fetch_instr SHALL hold its last value when fetch_valid=0.
REQ-029 reload=1 in RUN SHALL, next cycle, enter LOAD with word_ptr=0, byte counter=0 and load_count=0; memory contents SHALL be retained until overwritten.
REQ-030 A fetch_req in the same cycle as reload SHALL still receive its response.
REQ-031 reload in LOAD SHALL be ignored.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL set: state=LOAD, every mem word=NOP_WORD, word_ptr=0, byte counter=0, load_count=0, load_ready=1, load_done=0, fetch_valid=0, fetch_err=0, fetch_instr=0.
REQ-033 rst SHALL override all other inputs, including mid-word load and in-flight fetches; the pending fetch response SHALL be discarded.

Verification
REQ-034 Stream bytes 13 05 A0 00 with load_last on the last byte -> mem[0]=32'h00A00513, load_count=1, load_done=1 next cycle; fetch_addr=0 -> fetch_instr=32'h00A00513 one cycle later.
REQ-035 Send 128 bytes with load_valid held at 1 -> after 32 writes, load_ready=0 and the 129th byte is not accepted; fetch_addr=8'h7C returns word 31.
REQ-036 Send 6 bytes 11 22 33 44 55 66 with load_last on 66 -> mem[1]=32'h00006655, mem[2..31]=32'h00000013.
REQ-037 In RUN, fetch_addr=8'h06 -> fetch_err=1 and instr=32'h00000013; fetch_addr=8'h80 -> fetch_err=1.
REQ-038 Assert reload concurrently with fetch_req to 0 -> the response is delivered, load_done=0 the next cycle, and reloading 4 bytes overwrites only mem[0].
REQ-039 Assert rst after 2 bytes of a word -> load_count=0, mem[0]=32'h00000013, and fetch_valid=0.
